tx_serial_8n1: RTL

TX_SERIAL_8N1 -- requirements
Module: tx_serial_8N1

---
 rtl/tx_serial_8n1.sv | 106 ++++++++++
 1 files changed

// File: rtl/tx_serial_8n1.sv
// 8N1 serial transmitter: a byte accepted on partida leaves LSB-first in 10*DIVISOR cycles, then one FINAL cycle pulses pronto.
// No input buffering: partida is honoured only while idle; ocupado tells the source to wait.
module tx_serial_8n1 #(
    parameter int DIVISOR = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dados_ascii,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int TICK_W = $clog2(DIVISOR);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIVISOR - 1);

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        TRANSMISSAO = 2'd1,
        FINAL       = 2'd2
    } state_t;

    state_t            state, stateNext;
    logic [9:0]        shiftReg, shiftNext;
    logic [TICK_W-1:0] tickCount, tickNext;
    logic [3:0]        bitCount, bitNext;
    logic              lineReg, lineNext;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= OCIOSO;
            shiftReg  <= '0;
            tickCount <= '0;
            bitCount  <= '0;
            lineReg   <= 1'b1;
        end else begin
            state     <= stateNext;
            shiftReg  <= shiftNext;
            tickCount <= tickNext;
            bitCount  <= bitNext;
            lineReg   <= lineNext;
        end
    end

    always_comb begin
        stateNext = state;
        shiftNext = shiftReg;
        tickNext  = tickCount;
        bitNext   = bitCount;
        lineNext  = lineReg;
        ocupado   = 1'b0;
        pronto    = 1'b0;

        case (state)
            OCIOSO: begin
                lineNext = 1'b1;
                if (partida) begin
                    stateNext = TRANSMISSAO;
                    shiftNext = {1'b1, dados_ascii, 1'b0};
                    tickNext  = '0;
                    bitNext   = '0;
                    lineNext  = 1'b0;
                end
            end
            TRANSMISSAO: begin
                ocupado  = 1'b1;
                // The line always mirrors the shift register LSB while a frame is on the wire.
                lineNext = shiftReg[0];
                if (tickCount == TICK_LAST) begin
                    tickNext = '0;
                    if (bitCount == 4'd9) begin
                        stateNext = FINAL;
                        lineNext  = 1'b1;
                    end else begin
                        shiftNext = {1'b1, shiftReg[9:1]};
                        lineNext  = shiftReg[1];
                        bitNext   = bitCount + 4'd1;
                    end
                end else begin
                    tickNext = tickCount + 1'b1;
                end
            end
            FINAL: begin
                ocupado   = 1'b1;
                pronto    = 1'b1;
                stateNext = OCIOSO;
                tickNext  = '0;
                bitNext   = '0;
                lineNext  = 1'b1;
            end
            default: begin
                stateNext = OCIOSO;
                shiftNext = '0;
                tickNext  = '0;
                bitNext   = '0;
                lineNext  = 1'b1;
            end
        endcase
    end

    assign saida_serial = lineReg;
    assign db_estado    = {2'b00, state};

endmodule
